// File: rtl/kda_job_serializer_pkg.sv
// Shared types and constants for the KDA job serializer.
package kda_job_serializer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      PASS = 2'd2,
      SALT = 2'd3
   } kda_state_e;

   localparam int unsigned BEATS_PER_JOB   = 17;
   localparam int unsigned WORDS_PER_FIELD = 8;
   localparam int unsigned HDR_RSVD_W      = 24;

   // Header beat layout
   localparam int unsigned HDR_CHUNKS_MSB = 63;
   localparam int unsigned HDR_CHUNKS_LSB = 62;
   localparam int unsigned HDR_SLEN_MSB   = 61;
   localparam int unsigned HDR_SLEN_LSB   = 56;
   localparam int unsigned HDR_RSVD_LSB   = 32;
   localparam int unsigned HDR_ITERS_MSB  = 31;
   localparam int unsigned HDR_ITERS_LSB  = 0;

   typedef struct packed {
      logic [1:0]   chunks;
      logic [5:0]   salt_len;
      logic [31:0]  iters;
      logic [511:0] pass;
      logic [511:0] salt;
   } kda_job_t;

endpackage

// File: rtl/kda_job_serializer_if.sv
// Job descriptor input and beat output handshake bundle.
interface kda_job_serializer_if;
   logic [1:0]   chunks_i;
   logic [5:0]   salt_len_i;
   logic [31:0]  iters_i;
   logic [511:0] pass_i;
   logic [511:0] salt_i;
   logic         v_i;
   logic         ready_o;
   logic [63:0]  data_o;
   logic         v_o;
   logic         ready_i;
   logic         busy_o;

   // Driver / consumer side
   modport master (
      output chunks_i, salt_len_i, iters_i, pass_i, salt_i, v_i, ready_i,
      input  ready_o, data_o, v_o, busy_o
   );

   // Serializer side
   modport slave (
      input  chunks_i, salt_len_i, iters_i, pass_i, salt_i, v_i, ready_i,
      output ready_o, data_o, v_o, busy_o
   );
endinterface

// File: rtl/kda_word_sel.sv
// Selects one 64-bit word from a packed vector; index 0 is the most significant word.
module kda_word_sel #(
   parameter int unsigned NUM_WORDS = 8
) (
   input  logic [NUM_WORDS*64-1:0] vec,
   input  logic [2:0]              idx,
   output logic [63:0]             word
);

   // Word mux, MSW first
   always_comb begin
      word = '0;
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
         if (idx == 3'(i)) word = vec[(NUM_WORDS-1-i)*64 +: 64];
      end
   end

endmodule

// File: rtl/kda_job_serializer.sv
// Captures a PBKDF2 job descriptor and streams it as header + pass + salt beats.
module kda_job_serializer
   import kda_job_serializer_pkg::*;
#(
   parameter int unsigned NUM_WORDS = WORDS_PER_FIELD
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   kda_job_serializer_if.slave   bus
);

   kda_state_e   state_q, state_d;
   logic [2:0]   cnt_q, cnt_d;
   kda_job_t     job_q;
   logic         accept, xfer, last_word;
   logic [511:0] sel_vec;
   logic [63:0]  sel_word;
   logic [63:0]  hdr;

   assign last_word = (cnt_q == 3'(NUM_WORDS-1));
   assign xfer      = bus.v_o && bus.ready_i;
   assign accept    = bus.v_i && bus.ready_o;

   // Handshake outputs; ready also opens on the final salt beat for back-to-back jobs
   always_comb begin
      bus.ready_o = (state_q == IDLE && !reset_i) ||
                    (state_q == SALT && last_word && bus.ready_i);
      bus.v_o     = (state_q != IDLE);
      bus.busy_o  = (state_q != IDLE);
   end

   // Next-state and word counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (accept) state_d = HDR;
         HDR: begin
            if (xfer) begin
               state_d = PASS;
               cnt_d   = '0;
            end
         end
         PASS: begin
            if (xfer) begin
               if (last_word) begin
                  state_d = SALT;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
         end
         SALT: begin
            if (xfer) begin
               if (last_word) begin
                  state_d = accept ? HDR : IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Job register, written only on acceptance
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         job_q <= '0;
      end else if (accept) begin
         job_q.chunks   <= bus.chunks_i;
         job_q.salt_len <= bus.salt_len_i;
         job_q.iters    <= bus.iters_i;
         job_q.pass     <= bus.pass_i;
         job_q.salt     <= bus.salt_i;
      end
   end

   // Header assembly and field select for the shared word mux
   always_comb begin
      hdr = '0;
      hdr[HDR_CHUNKS_MSB:HDR_CHUNKS_LSB]   = job_q.chunks;
      hdr[HDR_SLEN_MSB:HDR_SLEN_LSB]       = job_q.salt_len;
      hdr[HDR_RSVD_LSB +: HDR_RSVD_W]      = '0;
      hdr[HDR_ITERS_MSB:HDR_ITERS_LSB]     = job_q.iters;
      sel_vec = (state_q == SALT) ? job_q.salt : job_q.pass;
   end

   kda_word_sel #(
      .NUM_WORDS (NUM_WORDS)
   ) u_word_sel (
      .vec  (sel_vec),
      .idx  (cnt_q),
      .word (sel_word)
   );

   // Output beat mux; zero when idle
   always_comb begin
      bus.data_o = '0;
      case (state_q)
         HDR:        bus.data_o = hdr;
         PASS, SALT: bus.data_o = sel_word;
         default:    bus.data_o = '0;
      endcase
   end

endmodule

// File: tb/tb_kda_job_serializer.sv
// Scoreboard bench for kda_job_serializer: directed jobs, stalls, back-to-back, reset.
module tb_kda_job_serializer;

   logic clk_i = 1'b0;
   logic reset_i;

   kda_job_serializer_if jif ();

   kda_job_serializer #(
      .NUM_WORDS (8)
   ) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .bus     (jif)
   );

   always #5 clk_i = ~clk_i;

   logic [63:0] exp_q[$];
   int          n_checks = 0;
   int          n_err    = 0;
   int          bidx     = 0;
   int          hdr_seen = 0;
   int          jobs_acc = 0;
   int          rdy_mode = 0;
   bit          held     = 1'b0;
   logic [63:0] held_data;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Stimulus word pattern: word k (k=0 least significant) of pass or salt
   function automatic logic [63:0] word_val(input int style, input bit is_salt, input int k);
      if (style == 0)
         return is_salt ? 64'(32'hA0 + k) : 64'h1111_1111_1111_1111 * 64'(k);
      return {16'(style), (is_salt ? 16'hCAFE : 16'hBEEF), 32'(k)};
   endfunction

   // Downstream ready: constant high, or 1,0,0,1 repeating
   initial begin
      int ph = 0;
      jif.ready_i = 1'b1;
      forever begin
         @(posedge clk_i);
         #1;
         if (rdy_mode == 0) begin
            jif.ready_i = 1'b1;
         end else begin
            jif.ready_i = (ph == 0 || ph == 3);
            ph = (ph + 1) % 4;
         end
      end
   end

   // Monitor: compare each transferred beat against the scoreboard and check stall stability
   always @(negedge clk_i) begin
      if (reset_i) begin
         bidx = 0;
         held = 1'b0;
      end else begin
         if (held) chk("stall_stable", jif.data_o, held_data);
         held      = jif.v_o && !jif.ready_i;
         held_data = jif.data_o;
         if (jif.v_o && jif.ready_i) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", jif.data_o, 64'hx);
            end else begin
               chk($sformatf("beat%0d", bidx), jif.data_o, exp_q.pop_front());
            end
            if (bidx == 0) hdr_seen++;
            bidx = (bidx == 16) ? 0 : bidx + 1;
         end
      end
   end

   // Offer a job (called at posedge+1); pushes the 17 expected beats on acceptance
   task automatic submit(input logic [1:0] ch, input logic [5:0] sl, input logic [31:0] it,
                         input int style, input logic [63:0] exp_hdr,
                         input bit b2b, input int prev_style);
      bit ok = 1'b0;
      jif.chunks_i   = ch;
      jif.salt_len_i = sl;
      jif.iters_i    = it;
      for (int k = 0; k < 8; k++) begin
         jif.pass_i[64*k +: 64] = word_val(style, 1'b0, k);
         jif.salt_i[64*k +: 64] = word_val(style, 1'b1, k);
      end
      jif.v_i = 1'b1;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk_i);
         if (jif.ready_o) begin
            ok = 1'b1;
            if (b2b) begin
               chk("b2b_busy", 64'(jif.busy_o), 64'd1);
               chk("b2b_last_salt", jif.data_o, word_val(prev_style, 1'b1, 0));
            end
            exp_q.push_back(exp_hdr);
            for (int j = 0; j < 8; j++) exp_q.push_back(word_val(style, 1'b0, 7 - j));
            for (int j = 0; j < 8; j++) exp_q.push_back(word_val(style, 1'b1, 7 - j));
            jobs_acc++;
            break;
         end
      end
      if (!ok) chk("accept_timeout", 64'd0, 64'd1);
      @(posedge clk_i);
      #1;
      jif.v_i = 1'b0;
      if (b2b) begin
         @(negedge clk_i);
         chk("b2b_hdr_vo", 64'(jif.v_o), 64'd1);
         chk("b2b_hdr_next", jif.data_o, exp_hdr);
      end
   endtask

   task automatic drain();
      bit ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk_i);
         if (exp_q.size() == 0 && !jif.busy_o) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      bit ok;
      reset_i        = 1'b1;
      jif.v_i        = 1'b0;
      jif.chunks_i   = '0;
      jif.salt_len_i = '0;
      jif.iters_i    = '0;
      jif.pass_i     = '0;
      jif.salt_i     = '0;

      // Reset state
      repeat (2) @(posedge clk_i);
      #2;
      chk("rst_v_o", 64'(jif.v_o), 64'd0);
      chk("rst_busy", 64'(jif.busy_o), 64'd0);
      chk("rst_data", jif.data_o, 64'd0);
      chk("rst_ready", 64'(jif.ready_o), 64'd0);
      @(posedge clk_i);
      #1;
      reset_i = 1'b0;
      #1;
      chk("rel_ready", 64'(jif.ready_o), 64'd1);
      chk("rel_busy", 64'(jif.busy_o), 64'd0);
      chk("rel_v_o", 64'(jif.v_o), 64'd0);
      @(posedge clk_i);
      #1;

      // Reference job, continuous ready
      submit(2'd3, 6'd20, 32'h0000_1000, 0, 64'hD400_0000_0000_1000, 1'b0, 0);
      drain();

      // Same job under 1,0,0,1 ready pattern
      rdy_mode = 1;
      submit(2'd3, 6'd20, 32'h0000_1000, 0, 64'hD400_0000_0000_1000, 1'b0, 0);
      drain();
      rdy_mode = 0;
      @(posedge clk_i);
      #1;

      // Back-to-back: second job offered while the first streams
      submit(2'd2, 6'd16, 32'h0000_0100, 1, 64'h9000_0000_0000_0100, 1'b0, 0);
      submit(2'd1, 6'd5, 32'h0000_002A, 2, 64'h4500_0000_0000_002A, 1'b1, 1);
      drain();

      // Extreme header fields
      submit(2'd0, 6'd63, 32'hFFFF_FFFF, 4, 64'h3F00_0000_FFFF_FFFF, 1'b0, 0);
      drain();

      // Descriptor pulsed while in PASS must be ignored
      submit(2'd3, 6'd20, 32'h0000_1000, 0, 64'hD400_0000_0000_1000, 1'b0, 0);
      repeat (3) @(posedge clk_i);
      #1;
      jif.chunks_i = 2'd1;
      jif.iters_i  = 32'hDEAD_BEEF;
      jif.pass_i   = {8{64'h5555_5555_5555_5555}};
      jif.salt_i   = {8{64'h6666_6666_6666_6666}};
      jif.v_i      = 1'b1;
      @(negedge clk_i);
      chk("busy_ready_low", 64'(jif.ready_o), 64'd0);
      @(posedge clk_i);
      #1;
      jif.v_i = 1'b0;
      drain();

      // Asynchronous reset while beat 5 is presented
      submit(2'd3, 6'd0, 32'h0000_0007, 3, 64'hC000_0000_0000_0007, 1'b0, 0);
      ok = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(posedge clk_i);
         #2;
         if (bidx == 5) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("beat5_timeout", 64'(bidx), 64'd5);
      #1;
      reset_i = 1'b1;
      #1;
      chk("mid_rst_v_o", 64'(jif.v_o), 64'd0);
      chk("mid_rst_busy", 64'(jif.busy_o), 64'd0);
      chk("mid_rst_data", jif.data_o, 64'd0);
      chk("mid_rst_ready", 64'(jif.ready_o), 64'd0);
      chk("mid_rst_left", 64'(exp_q.size()), 64'd12);
      exp_q.delete();
      jobs_acc--;
      hdr_seen--;
      repeat (2) @(posedge clk_i);
      #1;
      reset_i = 1'b0;
      #1;
      chk("mid_rel_ready", 64'(jif.ready_o), 64'd1);
      @(posedge clk_i);
      #1;
      submit(2'd2, 6'd32, 32'h1234_5678, 5, 64'hA000_0000_1234_5678, 1'b0, 0);
      drain();

      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      chk("job_vs_hdr_count", 64'(hdr_seen), 64'(jobs_acc));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/kda_job_serializer.md
KDA_JOB_SERIALIZER -- requirements
Module: kda_job_serializer

Interface
REQ-001 Parameter NUM_WORDS, default 8: 64-bit words per 512-bit pass or salt field; fixed at 8.
REQ-002 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset_i  input  1  asynchronous, active-high reset.
REQ-004 chunks_i  input  2  job chunk-count code (0..3 means 1..4 PBKDF2 chunks).
REQ-005 salt_len_i  input  6  salt length in bytes.
REQ-006 iters_i  input  32  PBKDF2 iteration count.
REQ-007 pass_i  input  512  password block.
REQ-008 salt_i  input  512  salt block.
REQ-009 v_i  input  1  job descriptor valid.
REQ-010 ready_o  output  1  serializer can accept a job descriptor.
REQ-011 data_o  output  64  serialized beat to the downstream key-derivation accelerator.
REQ-012 v_o  output  1  data_o valid.
REQ-013 ready_i  input  1  downstream accepts a beat.
REQ-014 busy_o  output  1  a job is held or being streamed.

Function
REQ-015 A job is accepted when v_i and ready_o are both high at a rising edge; all descriptor fields are captured into an internal job register in that cycle.
REQ-016 A beat is transferred when v_o and ready_i are both high at a rising edge.
REQ-017 Each job is emitted as exactly 17 beats, in order: beat 0 header, beats 1-8 pass, beats 9-16 salt.
REQ-018 Header beat: [63:62] chunks, [61:56] salt_len, [55:32] zero, [31:0] iters.
REQ-019 Pass beats: beat 1 carries pass[511:448], and each following beat carries the next lower 64-bit word, ending with beat 8 = pass[63:0].
REQ-020 Salt beats 9-16 use the same most-significant-word-first order, from salt[511:448] down to salt[63:0].
REQ-021 FSM states and transitions:
- IDLE -> HDR on job accept.
- HDR -> PASS on a header transfer.
- PASS -> SALT on the transfer of the 8th pass word.
- SALT -> IDLE on the transfer of the 8th salt word, unless a new job is accepted in the same cycle, in which case SALT -> HDR.
REQ-022 A 3-bit word counter indexes words in PASS and SALT; it clears on entry to PASS and on entry to SALT, and increments once per transfer.
REQ-023 v_o is high in HDR, PASS and SALT, and low in IDLE.
REQ-024 ready_o is high in IDLE, and also in SALT when the counter equals 7 and ready_i is high (back-to-back acceptance); it is low otherwise.
REQ-025 Back-to-back timing: the header of a job accepted under REQ-024 appears on data_o in the cycle immediately after the final salt beat, with no idle bubble.
REQ-026 data_o is held stable while v_o is high and ready_i is low; the captured job register does not change while busy_o is high, except at a REQ-024 acceptance.
REQ-027 busy_o equals (state != IDLE).
REQ-028 Latency: the header is presented with v_o high in the cycle after job accept; with ready_i held high, a job completes in 17 consecutive cycles.
REQ-029 Input fields are not range-checked; salt_len values 0..63 pass through unmodified.
REQ-030 v_i while ready_o is low has no effect.

Reset
REQ-031 While reset_i is asserted:
- state is IDLE and the counter is 0;
- v_o = 0, busy_o = 0 and data_o = 0;
- ready_o is 0 during reset and 1 from the first cycle after release.
REQ-032 Asserting reset_i mid-job abandons the job with no further beats; the next job restarts at the header.

Structure
REQ-033 The shared kda package holds the following:
- the state enum (IDLE, HDR, PASS, SALT);
- the constants BEATS_PER_JOB = 17, WORDS_PER_FIELD = 8 and HDR_RSVD_W = 24;
- the header field bit positions.
REQ-034 A 512-to-64 word-select mux, kda_word_sel (512-bit vector plus 3-bit index in, 64-bit word out, index 0 = most significant word), is the only sub-module and is instantiated once, its vector input muxed between pass and salt by state.

Verification
REQ-035 Job chunks=3, salt_len=20, iters=0x00001000, pass word k = 0x1111_1111_1111_1111*k, salt word k = 0xA0+k, ready_i=1 -> 17 contiguous beats:
- header = 0xD400_0000_0000_1000;
- then pass words, most significant first;
- then salt words, most significant first.
REQ-036 Same job with ready_i toggled 1,0,0,1 repeating -> identical 17-beat sequence, and data_o stable during every stall.
REQ-037 Two jobs, the second offered with v_i high throughout -> the second job is accepted in the cycle of the first job's beat 16, and its header appears the next cycle.
REQ-038 reset_i asserted asynchronously during beat 5 -> v_o falls immediately; after release, a new job emits from its header and no residue of the old job appears.
REQ-039 chunks=0, salt_len=63, iters=0xFFFF_FFFF -> header = 0x3F00_0000_FFFF_FFFF.
REQ-040 v_i pulsed while busy (state PASS) -> the descriptor is ignored, and the job count equals the header count.
